// File: rtl/hazard_unit_pkg.sv
// Shared pipeline encodings used by the hazard unit: redirect select,
// forwarding selects and the memory-wait state machine states.
package hazard_unit_pkg;

    localparam logic [2:0] PC_NEXT  = 3'b000;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ERROR = 2'b10
    } mem_state_e;

    // The memory stage is younger than writeback, so its result wins.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Performance counter that counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W-1:0] FULL = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != FULL)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/redirect/memory-wait
// stall and flush control, memory timeout detection and event counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1_D,
    input  logic [4:0]       Rs2_D,
    input  logic [4:0]       Rs1_E,
    input  logic [4:0]       Rs2_E,
    input  logic [4:0]       Rd_E,
    input  logic             MemRead_E,
    input  logic [2:0]       PCsrc_E,
    input  logic [4:0]       Rd_M,
    input  logic [4:0]       Rd_W,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             MemReq_M,
    input  logic             MemReady_M,
    output logic             Stall_F,
    output logic             Stall_D,
    output logic             Stall_E,
    output logic             Stall_M,
    output logic             Flush_D,
    output logic             Flush_E,
    output logic             Flush_W,
    output logic [1:0]       ForwardA_E,
    output logic [1:0]       ForwardB_E,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] LoadUseCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] MemStallCnt
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    mem_state_e        state_q, state_d, state_eff;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;

    logic mem_miss, memstall, redirect, loaduse;
    logic win_mem, win_redir, win_lu;

    // While rst is high the outputs behave as if already back in RUN.
    always_comb begin
        if (rst) begin
            state_eff = ST_RUN;
        end else begin
            state_eff = state_q;
        end
    end

    always_comb begin
        mem_miss  = MemReq_M & ~MemReady_M;
        memstall  = (state_eff == ST_ERROR)
                  | ((state_eff == ST_WAIT) & ~MemReady_M)
                  | mem_miss;
        redirect  = (PCsrc_E != PC_NEXT);
        loaduse   = MemRead_E & (Rd_E != 5'd0) & ((Rd_E == Rs1_D) | (Rd_E == Rs2_D));
        win_mem   = memstall;
        win_redir = ~memstall & redirect;
        win_lu    = ~memstall & ~redirect & loaduse;
    end

    always_comb begin
        Stall_F    = win_mem | win_lu;
        Stall_D    = win_mem | win_lu;
        Stall_E    = win_mem;
        Stall_M    = win_mem;
        Flush_D    = win_redir;
        Flush_E    = win_redir | win_lu;
        Flush_W    = win_mem;
        ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
        ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
    end

    // Memory-wait state machine: the ready cycle itself is not stalled.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (mem_miss) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_ONE;
                end else begin
                    state_d = ST_RUN;
                    wait_d  = WAIT_ZERO;
                end
            end
            ST_WAIT: begin
                if (MemReady_M) begin
                    state_d = ST_RUN;
                    wait_d  = WAIT_ZERO;
                end else if (wait_q == TIMEOUT_V) begin
                    state_d   = ST_ERROR;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_ERROR: begin
                state_d   = ST_ERROR;
                timeout_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = WAIT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            wait_q    <= WAIT_ZERO;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign MemTimeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_loaduse_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (win_lu),
        .cnt_o (LoadUseCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (win_redir),
        .cnt_o (FlushCnt)
    );

    sat_counter #(.W(CNT_W)) u_memstall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (win_mem),
        .cnt_o (MemStallCnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: two instances (long and short memory
// timeout) checked every cycle against a rule-level model plus literal pins.
module tb_hazard_unit;

    localparam int CW    = 3;
    localparam int MT_A  = 8;
    localparam int MT_B  = 3;
    localparam int CMAX  = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       MemRead_E, RegWrite_M, RegWrite_W, MemReq_M, MemReady_M;
    logic [2:0] PCsrc_E;

    logic          sf[2], sd[2], se[2], sm[2], fd[2], fe[2], fw[2], mto[2];
    logic [1:0]    fa[2], fb[2];
    logic [CW-1:0] luc[2], flc[2], msc[2];

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model state: per instance
    bit m_wait[2], m_dead[2], m_to[2];
    int m_waited[2], m_lu[2], m_fl[2], m_ms[2];

    always #5 clk = ~clk;

    hazard_unit #(.MEM_TIMEOUT(MT_A), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .MemRead_E(MemRead_E), .PCsrc_E(PCsrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .MemReq_M(MemReq_M),
        .MemReady_M(MemReady_M), .Stall_F(sf[0]), .Stall_D(sd[0]), .Stall_E(se[0]),
        .Stall_M(sm[0]), .Flush_D(fd[0]), .Flush_E(fe[0]), .Flush_W(fw[0]),
        .ForwardA_E(fa[0]), .ForwardB_E(fb[0]), .MemTimeout(mto[0]),
        .LoadUseCnt(luc[0]), .FlushCnt(flc[0]), .MemStallCnt(msc[0])
    );

    hazard_unit #(.MEM_TIMEOUT(MT_B), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .MemRead_E(MemRead_E), .PCsrc_E(PCsrc_E), .Rd_M(Rd_M), .Rd_W(Rd_W),
        .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W), .MemReq_M(MemReq_M),
        .MemReady_M(MemReady_M), .Stall_F(sf[1]), .Stall_D(sd[1]), .Stall_E(se[1]),
        .Stall_M(sm[1]), .Flush_D(fd[1]), .Flush_E(fe[1]), .Flush_W(fw[1]),
        .ForwardA_E(fa[1]), .ForwardB_E(fb[1]), .MemTimeout(mto[1]),
        .LoadUseCnt(luc[1]), .FlushCnt(flc[1]), .MemStallCnt(msc[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int timeout_of(input int k);
        return (k == 0) ? MT_A : MT_B;
    endfunction

    // 0 = nothing, 1 = memory stall, 2 = redirect, 3 = load-use
    function automatic int winner(input int k);
        bit waiting, dead, load_use;
        waiting  = !rst && m_wait[k];
        dead     = !rst && m_dead[k];
        load_use = MemRead_E && (Rd_E != 5'd0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
        if (dead || (waiting && !MemReady_M) || (MemReq_M && !MemReady_M)) return 1;
        if (PCsrc_E != 3'd0) return 2;
        if (load_use) return 3;
        return 0;
    endfunction

    function automatic int fwd_exp(input logic [4:0] rs);
        if (RegWrite_M && Rd_M != 5'd0 && Rd_M == rs) return 2;
        if (RegWrite_W && Rd_W != 5'd0 && Rd_W == rs) return 1;
        return 0;
    endfunction

    function automatic int bump(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                int w;
                w = winner(k);
                chk($sformatf("Stall_F[%0d]", k), sf[k], (w == 1 || w == 3));
                chk($sformatf("Stall_D[%0d]", k), sd[k], (w == 1 || w == 3));
                chk($sformatf("Stall_E[%0d]", k), se[k], (w == 1));
                chk($sformatf("Stall_M[%0d]", k), sm[k], (w == 1));
                chk($sformatf("Flush_W[%0d]", k), fw[k], (w == 1));
                chk($sformatf("Flush_D[%0d]", k), fd[k], (w == 2));
                chk($sformatf("Flush_E[%0d]", k), fe[k], (w == 2 || w == 3));
                chk($sformatf("ForwardA_E[%0d]", k), fa[k], fwd_exp(Rs1_E));
                chk($sformatf("ForwardB_E[%0d]", k), fb[k], fwd_exp(Rs2_E));
                chk($sformatf("MemTimeout[%0d]", k), mto[k], m_to[k]);
                chk($sformatf("LoadUseCnt[%0d]", k), luc[k], m_lu[k]);
                chk($sformatf("FlushCnt[%0d]", k), flc[k], m_fl[k]);
                chk($sformatf("MemStallCnt[%0d]", k), msc[k], m_ms[k]);
            end
        end
    end

    // Model advance at each clock edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int w;
            w = winner(k);
            if (rst) begin
                m_wait[k] <= 1'b0; m_dead[k] <= 1'b0; m_to[k] <= 1'b0;
                m_waited[k] <= 0; m_lu[k] <= 0; m_fl[k] <= 0; m_ms[k] <= 0;
            end else begin
                if (w == 1) m_ms[k] <= bump(m_ms[k]);
                if (w == 2) m_fl[k] <= bump(m_fl[k]);
                if (w == 3) m_lu[k] <= bump(m_lu[k]);
                if (m_dead[k]) begin
                    m_to[k] <= 1'b1;
                end else if (m_wait[k]) begin
                    if (MemReady_M) begin
                        m_wait[k] <= 1'b0;
                    end else if (m_waited[k] == timeout_of(k)) begin
                        m_wait[k] <= 1'b0; m_dead[k] <= 1'b1; m_to[k] <= 1'b1;
                    end else begin
                        m_waited[k] <= m_waited[k] + 1;
                    end
                end else if (MemReq_M && !MemReady_M) begin
                    m_wait[k] <= 1'b1; m_waited[k] <= 1;
                end
            end
        end
    end

    task automatic idle();
        Rs1_D = 5'd0; Rs2_D = 5'd0; Rs1_E = 5'd0; Rs2_E = 5'd0; Rd_E = 5'd0;
        Rd_M = 5'd0; Rd_W = 5'd0; MemRead_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
        MemReq_M = 1'b0; MemReady_M = 1'b0; PCsrc_E = 3'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset Stall_F", sf[0], 1'b0);
        chk("reset LoadUseCnt", luc[0], 3'd0);
        chk("reset MemTimeout", mto[1], 1'b0);
        rst = 1'b0;
        tick();

        // load-use on Rs1_D, then on Rs2_D, then a load to x0
        MemRead_E = 1'b1; Rd_E = 5'd5; Rs1_D = 5'd5; Rs2_D = 5'd3;
        #1;
        chk("lu Stall_F", sf[0], 1'b1);
        chk("lu Flush_E", fe[0], 1'b1);
        chk("lu Stall_E", se[0], 1'b0);
        tick();
        idle();
        #1;
        chk("lu one cycle", sf[0], 1'b0);
        chk("lu count", luc[0], 3'd1);
        MemRead_E = 1'b1; Rd_E = 5'd5; Rs1_D = 5'd2; Rs2_D = 5'd5;
        tick();
        MemRead_E = 1'b1; Rd_E = 5'd0; Rs1_D = 5'd0; Rs2_D = 5'd0;
        #1;
        chk("lu x0 no stall", sf[0], 1'b0);
        tick();
        idle();

        // forwarding priority and x0
        RegWrite_M = 1'b1; RegWrite_W = 1'b1; Rd_M = 5'd7; Rd_W = 5'd7; Rs1_E = 5'd7;
        #1;
        chk("fwdA mem", fa[0], 2'b10);
        tick();
        Rd_M = 5'd0; Rs1_E = 5'd0;
        #1;
        chk("fwdA x0", fa[0], 2'b00);
        tick();
        Rs1_E = 5'd7; Rs2_E = 5'd7;
        #1;
        chk("fwdA wb", fa[0], 2'b01);
        tick();
        Rd_M = 5'd9; RegWrite_M = 1'b0; Rs2_E = 5'd9;
        #1;
        chk("fwdB no write", fb[0], 2'b00);
        tick();
        idle();

        // redirect beats load-use
        PCsrc_E = 3'b011; MemRead_E = 1'b1; Rd_E = 5'd4; Rs1_D = 5'd4;
        #1;
        chk("redir Flush_D", fd[0], 1'b1);
        chk("redir Flush_E", fe[0], 1'b1);
        chk("redir no stall", sf[0], 1'b0);
        tick();
        idle();
        #1;
        chk("redir FlushCnt", flc[0], 3'd1);
        chk("redir LoadUseCnt", luc[0], 3'd2);

        // memory stall beats redirect, then the ready cycle releases it
        MemReq_M = 1'b1; PCsrc_E = 3'b001;
        #1;
        chk("prio stall", sf[0], 1'b1);
        chk("prio no flush", fd[0], 1'b0);
        tick();
        PCsrc_E = 3'd0; MemReady_M = 1'b1;
        #1;
        chk("prio release", sf[0], 1'b0);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // four-cycle memory wait
        MemReq_M = 1'b1; MemReady_M = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("wait stall %0d", i), sf[0], 1'b1);
            chk($sformatf("wait Flush_W %0d", i), fw[0], 1'b1);
            tick();
        end
        MemReady_M = 1'b1;
        #1;
        chk("ready release", sf[0], 1'b0);
        chk("ready Flush_W", fw[0], 1'b0);
        tick();
        idle();
        #1;
        chk("MemStallCnt 4", msc[0], 3'd4);
        chk("short timeout hit", mto[1], 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // timeouts: short instance after 3 waits, long after 8
        MemReq_M = 1'b1; MemReady_M = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("timeout b set", mto[1], 1'b1);
        chk("timeout a clear", mto[0], 1'b0);
        MemReq_M = 1'b0; MemReady_M = 1'b1;
        #1;
        chk("error holds stall", sf[1], 1'b1);
        chk("wait released", sf[0], 1'b0);
        tick();
        MemReq_M = 1'b1; MemReady_M = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("timeout a set", mto[0], 1'b1);
        chk("MemStallCnt sat", msc[0], 3'd7);
        rst = 1'b1;
        #1;
        chk("rst memreq stall", sf[1], 1'b1);
        MemReq_M = 1'b0;
        #1;
        chk("rst no residual", sf[1], 1'b0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("post rst stall", sf[1], 1'b0);
        chk("post rst timeout", mto[1], 1'b0);
        chk("post rst count", msc[0], 3'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
